// File: rtl/adder_pkt_pkg.sv
// Shared constants and types for the adder packet controller.
package adder_pkt_pkg;

   // Frame headers and single-byte error responses
   localparam logic [7:0] HDR0     = 8'hFD;
   localparam logic [7:0] HDR1     = 8'hBA;
   localparam logic [7:0] ERR_CSUM = 8'hEE;
   localparam logic [7:0] ERR_MODE = 8'hEF;

   // Mode byte field positions
   localparam int unsigned MODE_SEL_LSB  = 0;
   localparam int unsigned MODE_CIN_BIT  = 2;
   localparam int unsigned MODE_RSVD_LSB = 3;

   typedef enum logic [1:0] {
      SEL_RCA  = 2'd0,
      SEL_CLA  = 2'd1,
      SEL_CSEA = 2'd2,
      SEL_CSA  = 2'd3
   } sel_e;

   // Mode byte as received: reserved bits must be zero
   typedef struct packed {
      logic [4:0] rsvd;
      logic       cin;
      sel_e       sel;
   } mode_t;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_HDR2,
      ST_MODE,
      ST_OPA,
      ST_OPB,
      ST_CSUM,
      ST_ADD,
      ST_TX,
      ST_TX_ERR
   } state_e;

endpackage

// File: rtl/adder_pkt_ctrl_if.sv
// UART byte stream and adder bus seen by the packet controller.
// master: controller side, slave: UART/adder side.
interface adder_pkt_ctrl_if #(parameter int unsigned W = 64);
   logic         rx_valid_i;
   logic [7:0]   rx_data_i;
   logic         tx_start_o;
   logic [7:0]   tx_data_o;
   logic         tx_done_i;
   logic [W-1:0] a_o;
   logic [W-1:0] b_o;
   logic         cin_o;
   logic [1:0]   sel_o;
   logic [W-1:0] sum_i;
   logic         cout_i;
   logic         busy_o;

   modport master (
      input  rx_valid_i, rx_data_i, tx_done_i, sum_i, cout_i,
      output tx_start_o, tx_data_o, a_o, b_o, cin_o, sel_o, busy_o
   );

   modport slave (
      output rx_valid_i, rx_data_i, tx_done_i, sum_i, cout_i,
      input  tx_start_o, tx_data_o, a_o, b_o, cin_o, sel_o, busy_o
   );
endinterface

// File: rtl/adder_pkt_ctrl_byte_assembler.sv
// N-byte little-endian shift-in register with byte counter.
// done_c flags the strobe that delivers the final byte.
module byte_assembler #(
   parameter int unsigned N = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           clr_i,
   input  logic           shift_i,
   input  logic [7:0]     data_i,
   output logic [8*N-1:0] value_o,
   output logic           done_c
);
   localparam int unsigned W     = 8 * N;
   localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [W-1:0]     value_q, value_d;
   logic [W+7:0]     shifted_c;

   // New byte enters at the top so the first byte ends up in the LSBs
   always_comb begin
      shifted_c = {data_i, value_q};
      value_d   = value_q;
      cnt_d     = cnt_q;
      done_c    = shift_i && (cnt_q == CNT_W'(N - 1));
      if (clr_i) begin
         cnt_d = '0;
      end else if (shift_i) begin
         value_d = shifted_c[W+7:8];
         cnt_d   = done_c ? '0 : cnt_q + CNT_W'(1);
      end
   end

   // Register update
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         value_q <= '0;
      end else begin
         cnt_q   <= cnt_d;
         value_q <= value_d;
      end
   end

   assign value_o = value_q;
endmodule

// File: rtl/adder_pkt_ctrl.sv
// Packet controller: UART request frames in, adder drive, framed response out.
// Optional inter-byte receive timeout enabled by defining ADDER_PKT_TIMEOUT_EN.
module adder_pkt_ctrl
   import adder_pkt_pkg::*;
#(
   parameter int unsigned OPERAND_BYTES  = 8,
   parameter int unsigned ADD_LATENCY    = 1,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input logic              clk,
   input logic              rst,
   adder_pkt_ctrl_if.master bus
);
   localparam int unsigned W     = 8 * OPERAND_BYTES;
   localparam int unsigned IDX_W = $clog2(OPERAND_BYTES + 4);

   // Reject out-of-range configurations at elaboration
   if (OPERAND_BYTES < 1 || OPERAND_BYTES > 16 || ADD_LATENCY < 1 ||
       ADD_LATENCY > 255 || TIMEOUT_CYCLES < 1) begin : g_param_err
      $error("adder_pkt_ctrl: illegal parameter value");
   end

   state_e           state_q, state_d;
   mode_t            mode_q, mode_d;
   logic [7:0]       rx_csum_q, rx_csum_d;
   logic [7:0]       lat_q, lat_d;
   logic [IDX_W-1:0] tx_idx_q, tx_idx_d;
   logic [7:0]       tx_csum_q, tx_csum_d;
   logic             tx_start_q, tx_start_d;
   logic [7:0]       tx_data_q, tx_data_d;
   logic [W-1:0]     a_q, a_d, b_q, b_d;
   sel_e             sel_q, sel_d;
   logic             cin_q, cin_d;
   logic             busy_q, busy_d;

   logic             asm_clr_c, a_shift_c, b_shift_c, a_done_c, b_done_c;
   logic [W-1:0]     a_shadow, b_shadow;
   logic [IDX_W-1:0] tx_nxt_c;
   logic [W-1:0]     sum_sh_c;
   logic [7:0]       tx_byte_c;

`ifdef ADDER_PKT_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] idle_q, idle_d;
`endif

   byte_assembler #(.N(OPERAND_BYTES)) u_asm_a (
      .clk(clk), .rst(rst), .clr_i(asm_clr_c), .shift_i(a_shift_c),
      .data_i(bus.rx_data_i), .value_o(a_shadow), .done_c(a_done_c)
   );

   byte_assembler #(.N(OPERAND_BYTES)) u_asm_b (
      .clk(clk), .rst(rst), .clr_i(asm_clr_c), .shift_i(b_shift_c),
      .data_i(bus.rx_data_i), .value_o(b_shadow), .done_c(b_done_c)
   );

   // Next response byte: headers, sum LSB first, carry, then checksum
   always_comb begin
      tx_nxt_c = tx_idx_q + IDX_W'(1);
      sum_sh_c = bus.sum_i >> (8 * (32'(tx_nxt_c) - 32'd2));
      if (tx_nxt_c == IDX_W'(1))
         tx_byte_c = HDR1;
      else if (tx_nxt_c <= IDX_W'(OPERAND_BYTES + 1))
         tx_byte_c = sum_sh_c[7:0];
      else if (tx_nxt_c == IDX_W'(OPERAND_BYTES + 2))
         tx_byte_c = {7'b0, bus.cout_i};
      else
         tx_byte_c = tx_csum_q;
   end

   // Next-state and output logic
   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      rx_csum_d  = rx_csum_q;
      lat_d      = lat_q;
      tx_idx_d   = tx_idx_q;
      tx_csum_d  = tx_csum_q;
      tx_start_d = 1'b0;
      tx_data_d  = tx_data_q;
      a_d        = a_q;
      b_d        = b_q;
      sel_d      = sel_q;
      cin_d      = cin_q;
      asm_clr_c  = state_q inside {ST_IDLE, ST_HDR2, ST_MODE};
      a_shift_c  = 1'b0;
      b_shift_c  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.rx_valid_i && bus.rx_data_i == HDR0) begin
               rx_csum_d = HDR0;
               state_d   = ST_HDR2;
            end
         end
         ST_HDR2: begin
            if (bus.rx_valid_i) begin
               if (bus.rx_data_i == HDR1) begin
                  rx_csum_d = rx_csum_q + bus.rx_data_i;
                  state_d   = ST_MODE;
               end else if (bus.rx_data_i == HDR0) begin
                  rx_csum_d = HDR0;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_MODE: begin
            if (bus.rx_valid_i) begin
               mode_d    = mode_t'(bus.rx_data_i);
               rx_csum_d = rx_csum_q + bus.rx_data_i;
               state_d   = ST_OPA;
            end
         end
         ST_OPA: begin
            if (bus.rx_valid_i) begin
               a_shift_c = 1'b1;
               rx_csum_d = rx_csum_q + bus.rx_data_i;
               if (a_done_c) state_d = ST_OPB;
            end
         end
         ST_OPB: begin
            if (bus.rx_valid_i) begin
               b_shift_c = 1'b1;
               rx_csum_d = rx_csum_q + bus.rx_data_i;
               if (b_done_c) state_d = ST_CSUM;
            end
         end
         ST_CSUM: begin
            if (bus.rx_valid_i) begin
               if (bus.rx_data_i != rx_csum_q) begin
                  state_d    = ST_TX_ERR;
                  tx_start_d = 1'b1;
                  tx_data_d  = ERR_CSUM;
               end else if (mode_q.rsvd != 5'd0) begin
                  state_d    = ST_TX_ERR;
                  tx_start_d = 1'b1;
                  tx_data_d  = ERR_MODE;
               end else begin
                  state_d = ST_ADD;
                  a_d     = a_shadow;
                  b_d     = b_shadow;
                  sel_d   = mode_q.sel;
                  cin_d   = mode_q.cin;
                  lat_d   = 8'd0;
               end
            end
         end
         ST_ADD: begin
            if (lat_q == 8'(ADD_LATENCY - 1)) begin
               state_d    = ST_TX;
               tx_start_d = 1'b1;
               tx_data_d  = HDR0;
               tx_idx_d   = '0;
               tx_csum_d  = HDR0;
            end else begin
               lat_d = lat_q + 8'd1;
            end
         end
         ST_TX: begin
            if (bus.tx_done_i) begin
               if (tx_idx_q == IDX_W'(OPERAND_BYTES + 3)) begin
                  state_d = ST_IDLE;
               end else begin
                  tx_idx_d   = tx_nxt_c;
                  tx_start_d = 1'b1;
                  tx_data_d  = tx_byte_c;
                  tx_csum_d  = tx_csum_q + tx_byte_c;
               end
            end
         end
         ST_TX_ERR: begin
            if (bus.tx_done_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

`ifdef ADDER_PKT_TIMEOUT_EN
      idle_d = '0;
      if (state_q inside {ST_HDR2, ST_MODE, ST_OPA, ST_OPB, ST_CSUM} && !bus.rx_valid_i) begin
         if (idle_q == TO_W'(TIMEOUT_CYCLES - 1))
            state_d = ST_IDLE;
         else
            idle_d = idle_q + TO_W'(1);
      end
`endif

      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         mode_q     <= '0;
         rx_csum_q  <= '0;
         lat_q      <= '0;
         tx_idx_q   <= '0;
         tx_csum_q  <= '0;
         tx_start_q <= 1'b0;
         tx_data_q  <= '0;
         a_q        <= '0;
         b_q        <= '0;
         sel_q      <= SEL_RCA;
         cin_q      <= 1'b0;
         busy_q     <= 1'b0;
`ifdef ADDER_PKT_TIMEOUT_EN
         idle_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         rx_csum_q  <= rx_csum_d;
         lat_q      <= lat_d;
         tx_idx_q   <= tx_idx_d;
         tx_csum_q  <= tx_csum_d;
         tx_start_q <= tx_start_d;
         tx_data_q  <= tx_data_d;
         a_q        <= a_d;
         b_q        <= b_d;
         sel_q      <= sel_d;
         cin_q      <= cin_d;
         busy_q     <= busy_d;
`ifdef ADDER_PKT_TIMEOUT_EN
         idle_q     <= idle_d;
`endif
      end
   end

   assign bus.tx_start_o = tx_start_q;
   assign bus.tx_data_o  = tx_data_q;
   assign bus.a_o        = a_q;
   assign bus.b_o        = b_q;
   assign bus.sel_o      = sel_q;
   assign bus.cin_o      = cin_q;
   assign bus.busy_o     = busy_q;
endmodule

// File: tb/tb_adder_pkt_ctrl.sv
// Bench for adder_pkt_ctrl with 2-byte operands and a 2-cycle adder latency.
module tb_adder_pkt_ctrl;
   localparam int unsigned N  = 2;
   localparam int unsigned W  = 8 * N;
   localparam int unsigned L  = 2;
   localparam int unsigned TO = 100;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   adder_pkt_ctrl_if #(.W(W)) ifc ();

   adder_pkt_ctrl #(.OPERAND_BYTES(N), .ADD_LATENCY(L), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .bus(ifc)
   );

   // Ideal adder
   assign {ifc.cout_i, ifc.sum_i} = (W+1)'(ifc.a_o) + (W+1)'(ifc.b_o) + (W+1)'(ifc.cin_o);

   int          checks = 0;
   int          errors = 0;
   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0]  req_q[$];
   logic [7:0]  junk_q[$];
   logic [7:0]  exp_q[$];
   logic [7:0]  cap_q[$];
   int unsigned cap_cyc[$];
   int unsigned done_q[$];
   int          dly = 0;

   // Capture transmitted bytes and answer each with tx_done three cycles later
   always @(negedge clk) begin
      ifc.tx_done_i = 1'b0;
      if (ifc.tx_start_o === 1'b1) begin
         cap_q.push_back(ifc.tx_data_o);
         cap_cyc.push_back(cyc);
         dly = 3;
      end else if (dly > 0) begin
         dly--;
         if (dly == 0) begin
            ifc.tx_done_i = 1'b1;
            done_q.push_back(cyc);
         end
      end
   end

   task automatic send_bytes(output int unsigned csum_cyc);
      int total;
      total = req_q.size() + junk_q.size();
      csum_cyc = 0;
      for (int i = 0; i <= total; i++) begin
         @(negedge clk);
         if (i == req_q.size()) csum_cyc = cyc;
         if (i < req_q.size()) begin
            ifc.rx_valid_i = 1'b1;
            ifc.rx_data_i  = req_q[i];
         end else if (i < total) begin
            ifc.rx_valid_i = 1'b1;
            ifc.rx_data_i  = junk_q[i - req_q.size()];
         end else begin
            ifc.rx_valid_i = 1'b0;
         end
      end
   endtask

   // Send req_q (plus junk_q), then pop exp_q against captured bytes
   task automatic run_frame(input string name, input int off);
      int          base, dbase, nexp, n;
      int unsigned cc;
      logic [7:0]  e;
      base  = cap_q.size();
      dbase = done_q.size();
      nexp  = exp_q.size();
      send_bytes(cc);
      n = 0;
      while (n < 500 && !((cap_q.size() - base) >= nexp && ifc.busy_o === 1'b0)) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 500) begin
         errors++;
         $display("FAIL %s_timeout: got %0d bytes, busy=%b, required %0d bytes and busy=0",
                  name, cap_q.size() - base, ifc.busy_o, nexp);
      end
      checks++;
      if (cap_q.size() - base != nexp) begin
         errors++;
         $display("FAIL %s_count: got %0d bytes, required %0d", name, cap_q.size() - base, nexp);
      end
      if (off >= 0 && cap_q.size() > base) begin
         checks++;
         if (cap_cyc[base] != cc + off) begin
            errors++;
            $display("FAIL %s_start: first tx_start at cycle %0d, required %0d",
                     name, cap_cyc[base], cc + off);
         end
      end
      for (int i = 0; i < nexp; i++) begin
         e = exp_q.pop_front();
         if (base + i < cap_q.size()) begin
            checks++;
            if (cap_q[base+i] !== e) begin
               errors++;
               $display("FAIL %s_byte%0d: got %h, required %h", name, i, cap_q[base+i], e);
            end
            if (i > 0 && dbase + i - 1 < done_q.size()) begin
               checks++;
               if (cap_cyc[base+i] != done_q[dbase+i-1] + 1) begin
                  errors++;
                  $display("FAIL %s_spacing%0d: tx_start at cycle %0d, required %0d",
                           name, i, cap_cyc[base+i], done_q[dbase+i-1] + 1);
               end
            end
         end
      end
      exp_q.delete();
      junk_q.delete();
   endtask

   task automatic check_adder(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [1:0] sel, input logic cin);
      checks++;
      if (ifc.a_o !== a || ifc.b_o !== b || ifc.sel_o !== sel || ifc.cin_o !== cin) begin
         errors++;
         $display("FAIL %s_adder: got a=%h b=%h sel=%0d cin=%b, required a=%h b=%h sel=%0d cin=%b",
                  name, ifc.a_o, ifc.b_o, ifc.sel_o, ifc.cin_o, a, b, sel, cin);
      end
   endtask

   task automatic check_reset_outputs(input string name);
      checks++;
      if (ifc.tx_start_o !== 1'b0 || ifc.tx_data_o !== 8'h00 || ifc.a_o !== '0 ||
          ifc.b_o !== '0 || ifc.cin_o !== 1'b0 || ifc.sel_o !== 2'd0 || ifc.busy_o !== 1'b0) begin
         errors++;
         $display("FAIL %s: got start=%b data=%h a=%h b=%h cin=%b sel=%0d busy=%b, required all zero",
                  name, ifc.tx_start_o, ifc.tx_data_o, ifc.a_o, ifc.b_o, ifc.cin_o, ifc.sel_o, ifc.busy_o);
      end
   endtask

   // Reference frame builder and response model
   task automatic build_frame(input logic [7:0] mode, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [7:0] cs, rc, bt;
      logic [W:0] s;
      req_q.delete();
      exp_q.delete();
      req_q.push_back(8'hFD);
      req_q.push_back(8'hBA);
      req_q.push_back(mode);
      cs = 8'hFD + 8'hBA + mode;
      for (int i = 0; i < int'(N); i++) begin
         bt = a[8*i +: 8];
         req_q.push_back(bt);
         cs = cs + bt;
      end
      for (int i = 0; i < int'(N); i++) begin
         bt = b[8*i +: 8];
         req_q.push_back(bt);
         cs = cs + bt;
      end
      req_q.push_back(cs);
      if (mode[7:3] != 5'd0) begin
         exp_q.push_back(8'hEF);
      end else begin
         s = {1'b0, a} + {1'b0, b} + (W+1)'(mode[2]);
         exp_q.push_back(8'hFD);
         exp_q.push_back(8'hBA);
         rc = 8'hFD + 8'hBA;
         for (int i = 0; i < int'(N); i++) begin
            bt = s[8*i +: 8];
            exp_q.push_back(bt);
            rc = rc + bt;
         end
         bt = {7'b0, s[W]};
         exp_q.push_back(bt);
         rc = rc + bt;
         exp_q.push_back(rc);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      ifc.rx_valid_i = 1'b0;
      ifc.rx_data_i  = 8'h00;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_basic();
      req_q = '{8'hFD, 8'hBA, 8'h00, 8'h34, 8'h12, 8'h01, 8'h00, 8'hFE};
      exp_q = '{8'hFD, 8'hBA, 8'h35, 8'h12, 8'h00, 8'hFE};
      run_frame("basic", int'(L));
      check_adder("basic", 16'h1234, 16'h0001, 2'd0, 1'b0);
   endtask

   task automatic test_cin();
      req_q = '{8'hFD, 8'hBA, 8'h04, 8'hFF, 8'hFF, 8'h01, 8'h00, 8'hBA};
      exp_q = '{8'hFD, 8'hBA, 8'h01, 8'h00, 8'h01, 8'hB9};
      run_frame("cin", int'(L));
      check_adder("cin", 16'hFFFF, 16'h0001, 2'd0, 1'b1);
   endtask

   task automatic test_csum_err();
      req_q = '{8'hFD, 8'hBA, 8'h00, 8'h34, 8'h12, 8'h01, 8'h00, 8'hFF};
      exp_q = '{8'hEE};
      run_frame("csum_err", 0);
      check_adder("csum_err", 16'hFFFF, 16'h0001, 2'd0, 1'b1);
   endtask

   task automatic test_mode_err();
      req_q = '{8'hFD, 8'hBA, 8'h08, 8'h34, 8'h12, 8'h01, 8'h00, 8'h06};
      exp_q = '{8'hEF};
      run_frame("mode_err", -1);
      check_adder("mode_err", 16'hFFFF, 16'h0001, 2'd0, 1'b1);
   endtask

   task automatic test_resync();
      req_q = '{8'h55, 8'hFD, 8'hFD, 8'hBA, 8'h00, 8'h34, 8'h12, 8'h01, 8'h00, 8'hFE};
      exp_q = '{8'hFD, 8'hBA, 8'h35, 8'h12, 8'h00, 8'hFE};
      run_frame("resync", int'(L));
      check_adder("resync", 16'h1234, 16'h0001, 2'd0, 1'b0);
   endtask

   // Random frames; the first is followed by bytes that arrive while busy
   task automatic test_back_to_back();
      logic [7:0]   mode;
      logic [W-1:0] a, b;
      for (int k = 0; k < 4; k++) begin
         mode = 8'($urandom_range(0, 7));
         a    = W'($urandom);
         b    = W'($urandom);
         if (k == 1) begin
            a = '1;
            b = '1;
            mode = 8'h07;
         end
         build_frame(mode, a, b);
         if (k == 0) junk_q = '{8'hFD, 8'hBA, 8'h00};
         run_frame($sformatf("b2b%0d", k), int'(L));
         check_adder($sformatf("b2b%0d", k), a, b, mode[1:0], mode[2]);
      end
   endtask

   task automatic test_reset_mid_tx();
      int          base, n;
      int unsigned cc;
      build_frame(8'h03, 16'hA5C3, 16'h1E2F);
      base = cap_q.size();
      send_bytes(cc);
      n = 0;
      while (n < 200 && cap_q.size() - base < 3) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 200) begin
         errors++;
         $display("FAIL rst_mid_wait: got %0d bytes, required 3", cap_q.size() - base);
      end
      rst = 1'b1;
      @(negedge clk);
      check_reset_outputs("rst_mid");
      rst = 1'b0;
      repeat (12) @(negedge clk);
      checks++;
      if (cap_q.size() - base != 3) begin
         errors++;
         $display("FAIL rst_mid_quiet: got %0d bytes, required 3", cap_q.size() - base);
      end
      exp_q.delete();
      build_frame(8'h01, 16'h00FF, 16'h0F01);
      run_frame("after_rst", int'(L));
      check_adder("after_rst", 16'h00FF, 16'h0F01, 2'd1, 1'b0);
   endtask

`ifdef ADDER_PKT_TIMEOUT_EN
   task automatic test_timeout();
      int          base;
      int unsigned cc;
      base  = cap_q.size();
      req_q = '{8'hFD, 8'hBA, 8'h00};
      send_bytes(cc);
      repeat (TO - 10) @(negedge clk);
      checks++;
      if (ifc.busy_o !== 1'b1) begin
         errors++;
         $display("FAIL timeout_early: busy=%b, required 1", ifc.busy_o);
      end
      repeat (15) @(negedge clk);
      checks++;
      if (ifc.busy_o !== 1'b0 || cap_q.size() != base) begin
         errors++;
         $display("FAIL timeout_idle: busy=%b bytes=%0d, required busy=0 bytes=0",
                  ifc.busy_o, cap_q.size() - base);
      end
      build_frame(8'h02, 16'h1111, 16'h2222);
      run_frame("after_timeout", int'(L));
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_cin();
      test_csum_err();
      test_mode_err();
      test_resync();
      test_back_to_back();
`ifdef ADDER_PKT_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid_tx();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
